bsg_axil_mm2s_rx_buffer: RTL and testbench

Per-slot receive buffer for the AXI-Lite memory-mapped-to-stream (mm2s) path of the manycore link. Accepts 32-bit words from the manycore endpoint side and holds them in a circular FIFO. Presents the head word to the AXI-Lite read-channel block, which pops one word per completed read of the data register. Also owns the slot's status/control registers (ISR, IER, RDFR, RDFO, RLR) and returns their values to that read block.

---
 rtl/bsg_manycore_link_to_axil_pkg.sv | 39 +++
 rtl/bsg_mem_1r1w.sv | 37 +++
 rtl/bsg_axil_mm2s_rx_buffer.sv | 157 +++++++++++++++
 tb/tb_bsg_axil_mm2s_rx_buffer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_link_to_axil_pkg.sv
// Shared constants for the manycore-link <-> AXI-Lite bridge.
//
// Purpose: slot-local register offsets for the mm2s (memory-mapped to
// stream) receive path, ISR/IER bit positions, the FIFO flush key and a
// small helper that packs the two implemented interrupt bits into a
// 32-bit register image.
//
// Ports: none (package).

package bsg_manycore_link_to_axil_pkg;

    // Width of a slot-local register offset on the AXI-Lite side.
    localparam int axil_base_addr_width_gp = 8;

    // mm2s slot-local register offsets.
    localparam logic [axil_base_addr_width_gp-1:0] axil_mm2s_ofs_isr_gp  = 8'h00;
    localparam logic [axil_base_addr_width_gp-1:0] axil_mm2s_ofs_ier_gp  = 8'h04;
    localparam logic [axil_base_addr_width_gp-1:0] axil_mm2s_ofs_rdfr_gp = 8'h18;
    localparam logic [axil_base_addr_width_gp-1:0] axil_mm2s_ofs_rdfo_gp = 8'h1C;
    localparam logic [axil_base_addr_width_gp-1:0] axil_mm2s_ofs_rdr_gp  = 8'h20;
    localparam logic [axil_base_addr_width_gp-1:0] axil_mm2s_ofs_rlr_gp  = 8'h24;

    // Implemented ISR/IER bits: receive complete and receive underrun.
    localparam int axil_mm2s_isr_rc_bit_gp   = 26;
    localparam int axil_mm2s_isr_rpue_bit_gp = 19;

    // Writing exactly this value to RDFR flushes the receive FIFO.
    localparam logic [31:0] axil_fifo_reset_key_gp = 32'h0000_00A5;

    // Place the RC and RPUE flags at their register bit positions.
    function automatic logic [31:0] axil_mm2s_irq_bits(input logic rc, input logic rpue);
        logic [31:0] bits;
        bits = '0;
        bits[axil_mm2s_isr_rc_bit_gp]   = rc;
        bits[axil_mm2s_isr_rpue_bit_gp] = rpue;
        return bits;
    endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// Simple dual-port register-file memory: one synchronous write port and
// one asynchronous (combinational) read port.
//
// Ports:
//   clk_i      clock
//   w_v_i      write enable
//   w_addr_i   write address
//   w_data_i   write data
//   r_addr_i   read address
//   r_data_o   read data (combinational from r_addr_i)
//
// Storage is intentionally not reset; validity is tracked by the owner.

module bsg_mem_1r1w #(
    parameter int width_p = 32,
    parameter int els_p   = 4,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_r [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_r[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bsg_axil_mm2s_rx_buffer.sv
// Per-slot receive buffer for the AXI-Lite mm2s path.
//
// Purpose: circular FIFO of 32-bit words filled from the manycore endpoint
// and drained one word per completed data-register read. Also holds the
// slot's ISR/IER and answers status-register reads (ISR, IER, RDFO, RLR).
//
// Ports:
//   clk_i, reset_i   clock, asynchronous active-high reset
//   data_i, v_i      incoming word and its valid
//   ready_o          buffer can accept (handshake v_i & ready_o)
//   data_o, v_o      head word (0 when empty) and non-empty flag
//   ready_i          pop request from the AXI-Lite read block
//   rd_addr_i        register offset being read
//   reg_data_o       combinational register read data
//   wr_v_i           register write strobe (already slot-decoded)
//   wr_addr_i        register write offset
//   wr_data_i        register write data
//   irq_o            registered |(ISR & IER)

module bsg_axil_mm2s_rx_buffer
    import bsg_manycore_link_to_axil_pkg::*;
#(
    parameter int els_p = 4,
    localparam int ptr_width_lp = $clog2(els_p),
    localparam int cnt_width_lp = $clog2(els_p + 1)
) (
    input  logic                               clk_i,
    input  logic                               reset_i,

    input  logic [31:0]                        data_i,
    input  logic                               v_i,
    output logic                               ready_o,

    output logic [31:0]                        data_o,
    output logic                               v_o,
    input  logic                               ready_i,

    input  logic [axil_base_addr_width_gp-1:0] rd_addr_i,
    output logic [31:0]                        reg_data_o,

    input  logic                               wr_v_i,
    input  logic [axil_base_addr_width_gp-1:0] wr_addr_i,
    input  logic [31:0]                        wr_data_i,

    output logic                               irq_o
);

    localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);

    logic [ptr_width_lp-1:0] rptr_r, wptr_r;
    logic [cnt_width_lp-1:0] cnt_r;

    logic isr_rc_r, isr_rpue_r;
    logic ier_rc_r, ier_rpue_r;
    logic irq_r;

    logic        push, pop, underrun;
    logic        wr_isr, wr_ier, flush;
    logic [31:0] mem_data;

    assign ready_o  = (cnt_r != full_cnt_lp);
    assign v_o      = (cnt_r != '0);
    assign push     = v_i & ready_o;
    assign pop      = ready_i & v_o;
    assign underrun = ready_i & ~v_o;

    assign wr_isr = wr_v_i & (wr_addr_i == axil_mm2s_ofs_isr_gp);
    assign wr_ier = wr_v_i & (wr_addr_i == axil_mm2s_ofs_ier_gp);
    assign flush  = wr_v_i & (wr_addr_i == axil_mm2s_ofs_rdfr_gp)
                           & (wr_data_i == axil_fifo_reset_key_gp);

    // Word storage; a push landing in a flush cycle is dropped, so it is
    // not written either.
    bsg_mem_1r1w #(
        .width_p(32),
        .els_p  (els_p)
    ) mem (
        .clk_i   (clk_i),
        .w_v_i   (push & ~flush),
        .w_addr_i(wptr_r),
        .w_data_i(data_i),
        .r_addr_i(rptr_r),
        .r_data_o(mem_data)
    );

    // Stale memory contents are never exposed when empty.
    assign data_o = v_o ? mem_data : '0;

    // Pointers and occupancy. Flush overrides any concurrent push/pop.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_r <= '0;
            wptr_r <= '0;
            cnt_r  <= '0;
        end else if (flush) begin
            rptr_r <= '0;
            wptr_r <= '0;
            cnt_r  <= '0;
        end else begin
            if (push) wptr_r <= wptr_r + ptr_width_lp'(1);
            if (pop)  rptr_r <= rptr_r + ptr_width_lp'(1);
            case ({push, pop})
                2'b10:   cnt_r <= cnt_r + cnt_width_lp'(1);
                2'b01:   cnt_r <= cnt_r - cnt_width_lp'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // ISR is write-1-to-clear with set taking priority over clear.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            isr_rc_r   <= 1'b0;
            isr_rpue_r <= 1'b0;
        end else begin
            isr_rc_r   <= push
                        | (isr_rc_r & ~(wr_isr & wr_data_i[axil_mm2s_isr_rc_bit_gp]));
            isr_rpue_r <= underrun
                        | (isr_rpue_r & ~(wr_isr & wr_data_i[axil_mm2s_isr_rpue_bit_gp]));
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ier_rc_r   <= 1'b0;
            ier_rpue_r <= 1'b0;
        end else if (wr_ier) begin
            ier_rc_r   <= wr_data_i[axil_mm2s_isr_rc_bit_gp];
            ier_rpue_r <= wr_data_i[axil_mm2s_isr_rpue_bit_gp];
        end
    end

    // Interrupt is registered from the current ISR/IER, so it trails them
    // by one cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= (isr_rc_r & ier_rc_r) | (isr_rpue_r & ier_rpue_r);
        end
    end

    assign irq_o = irq_r;

    always_comb begin
        reg_data_o = '0;
        case (rd_addr_i)
            axil_mm2s_ofs_isr_gp:  reg_data_o = axil_mm2s_irq_bits(isr_rc_r, isr_rpue_r);
            axil_mm2s_ofs_ier_gp:  reg_data_o = axil_mm2s_irq_bits(ier_rc_r, ier_rpue_r);
            axil_mm2s_ofs_rdfo_gp: reg_data_o = 32'(cnt_r);
            axil_mm2s_ofs_rlr_gp:  reg_data_o = v_o ? 32'd4 : 32'd0;
            axil_mm2s_ofs_rdr_gp:  reg_data_o = '0;
            default:               reg_data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_bsg_axil_mm2s_rx_buffer.sv
// Directed, table-driven bench for bsg_axil_mm2s_rx_buffer (els_p = 4).
// Each table row is one clock cycle: inputs driven after the falling edge,
// outputs compared shortly after that (state from previous rising edges).

module tb_bsg_axil_mm2s_rx_buffer;
    import bsg_manycore_link_to_axil_pkg::axil_base_addr_width_gp;

    localparam int AW = axil_base_addr_width_gp;

    localparam logic [31:0] ISR  = 32'h00;
    localparam logic [31:0] IER  = 32'h04;
    localparam logic [31:0] RDFR = 32'h18;
    localparam logic [31:0] RDFO = 32'h1C;
    localparam logic [31:0] RDR  = 32'h20;
    localparam logic [31:0] RLR  = 32'h24;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [31:0]   data_i;
    logic          v_i;
    logic          ready_o;
    logic [31:0]   data_o;
    logic          v_o;
    logic          ready_i;
    logic [AW-1:0] rd_addr_i;
    logic [31:0]   reg_data_o;
    logic          wr_v_i;
    logic [AW-1:0] wr_addr_i;
    logic [31:0]   wr_data_i;
    logic          irq_o;

    always #5 clk_i = ~clk_i;

    bsg_axil_mm2s_rx_buffer #(.els_p(4)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .data_i    (data_i),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .data_o    (data_o),
        .v_o       (v_o),
        .ready_i   (ready_i),
        .rd_addr_i (rd_addr_i),
        .reg_data_o(reg_data_o),
        .wr_v_i    (wr_v_i),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .irq_o     (irq_o)
    );

    typedef struct {
        logic [31:0] v, d, rdy, wv, wa, wd, ra;
        logic [31:0] er, ev, ed, eg, ei;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input logic [31:0] v, d, rdy, wv, wa, wd, ra,
                       input logic [31:0] er, ev, ed, eg, ei);
        vec_t r;
        r.v = v; r.d = d; r.rdy = rdy; r.wv = wv; r.wa = wa; r.wd = wd; r.ra = ra;
        r.er = er; r.ev = ev; r.ed = ed; r.eg = eg; r.ei = ei;
        tbl.push_back(r);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        reset_i   = 1'b1;
        data_i    = '0;
        v_i       = 1'b0;
        ready_i   = 1'b0;
        rd_addr_i = '0;
        wr_v_i    = 1'b0;
        wr_addr_i = '0;
        wr_data_i = '0;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;

        //   v  data      rdy wv wa    wd            ra      ready v  data_o    reg           irq
        // reset state, push three, drain three
        add(0, 0,        0, 0, 0,    0,            RDFO,   1, 0, 0,        0,            0);
        add(1, 'h11,     0, 0, 0,    0,            RDFO,   1, 0, 0,        0,            0);
        add(1, 'h22,     0, 0, 0,    0,            RDFO,   1, 1, 'h11,     1,            0);
        add(1, 'h33,     0, 0, 0,    0,            RDFO,   1, 1, 'h11,     2,            0);
        add(0, 0,        0, 0, 0,    0,            RDFO,   1, 1, 'h11,     3,            0);
        add(0, 0,        0, 0, 0,    0,            ISR,    1, 1, 'h11,     'h0400_0000,  0);
        add(0, 0,        1, 0, 0,    0,            RLR,    1, 1, 'h11,     4,            0);
        add(0, 0,        1, 0, 0,    0,            RDFO,   1, 1, 'h22,     2,            0);
        add(0, 0,        1, 0, 0,    0,            RDFO,   1, 1, 'h33,     1,            0);
        add(0, 0,        0, 0, 0,    0,            RLR,    1, 0, 0,        0,            0);
        add(0, 0,        0, 1, ISR,  'h0400_0000,  ISR,    1, 0, 0,        'h0400_0000,  0);
        add(0, 0,        0, 0, 0,    0,            ISR,    1, 0, 0,        0,            0);
        // underrun and interrupt
        add(0, 0,        1, 0, 0,    0,            RDFO,   1, 0, 0,        0,            0);
        add(0, 0,        0, 1, IER,  'h0008_0000,  ISR,    1, 0, 0,        'h0008_0000,  0);
        add(0, 0,        0, 0, 0,    0,            IER,    1, 0, 0,        'h0008_0000,  0);
        add(0, 0,        0, 1, ISR,  'h0008_0000,  ISR,    1, 0, 0,        'h0008_0000,  1);
        add(0, 0,        0, 0, 0,    0,            ISR,    1, 0, 0,        0,            1);
        add(0, 0,        0, 0, 0,    0,            RDFO,   1, 0, 0,        0,            0);
        add(0, 0,        0, 1, IER,  0,            IER,    1, 0, 0,        'h0008_0000,  0);
        // fill to full with v_i held, pop past the pointer wrap
        add(1, 'hA1,     0, 0, 0,    0,            RDFO,   1, 0, 0,        0,            0);
        add(1, 'hA2,     0, 0, 0,    0,            RDFO,   1, 1, 'hA1,     1,            0);
        add(1, 'hA3,     0, 0, 0,    0,            RDFO,   1, 1, 'hA1,     2,            0);
        add(1, 'hA4,     0, 0, 0,    0,            RDFO,   1, 1, 'hA1,     3,            0);
        add(1, 'hA5,     0, 0, 0,    0,            RDFO,   0, 1, 'hA1,     4,            0);
        add(1, 'hA5,     1, 0, 0,    0,            RDFO,   0, 1, 'hA1,     4,            0);
        add(1, 'hA5,     1, 0, 0,    0,            RDFO,   1, 1, 'hA2,     3,            0);
        add(1, 'hA6,     0, 0, 0,    0,            RDFO,   1, 1, 'hA3,     3,            0);
        add(0, 0,        1, 0, 0,    0,            RDFO,   0, 1, 'hA3,     4,            0);
        add(0, 0,        1, 0, 0,    0,            RDFO,   1, 1, 'hA4,     3,            0);
        add(0, 0,        1, 0, 0,    0,            RDFO,   1, 1, 'hA5,     2,            0);
        add(0, 0,        1, 0, 0,    0,            RDFO,   1, 1, 'hA6,     1,            0);
        add(0, 0,        0, 0, 0,    0,            RDFO,   1, 0, 0,        0,            0);
        // concurrent push/pop at count 2; W1C of RC during a push
        add(1, 'hB1,     0, 0, 0,    0,            RDFO,   1, 0, 0,        0,            0);
        add(1, 'hB2,     0, 0, 0,    0,            RDFO,   1, 1, 'hB1,     1,            0);
        add(1, 'hB3,     1, 0, 0,    0,            RDFO,   1, 1, 'hB1,     2,            0);
        add(0, 0,        0, 0, 0,    0,            RDFO,   1, 1, 'hB2,     2,            0);
        add(1, 'hB4,     0, 1, ISR,  'h0400_0000,  ISR,    1, 1, 'hB2,     'h0400_0000,  0);
        add(0, 0,        0, 0, 0,    0,            ISR,    1, 1, 'hB2,     'h0400_0000,  0);
        add(0, 0,        0, 1, ISR,  'h0400_0000,  RDFO,   1, 1, 'hB2,     3,            0);
        add(0, 0,        0, 0, 0,    0,            ISR,    1, 1, 'hB2,     0,            0);
        // flush: wrong key ignored, right key with concurrent push
        add(0, 0,        0, 1, RDFR, 'h5A,         RDFO,   1, 1, 'hB2,     3,            0);
        add(0, 0,        0, 0, 0,    0,            RDFO,   1, 1, 'hB2,     3,            0);
        add(1, 'hC1,     0, 1, RDFR, 'hA5,         RDFO,   1, 1, 'hB2,     3,            0);
        add(0, 0,        0, 0, 0,    0,            RDFO,   1, 0, 0,        0,            0);
        add(0, 0,        0, 0, 0,    0,            RLR,    1, 0, 0,        0,            0);
        add(1, 'hD1,     0, 0, 0,    0,            RDR,    1, 0, 0,        0,            0);
        add(0, 0,        0, 0, 0,    0,            RDR,    1, 1, 'hD1,     0,            0);
        add(0, 0,        0, 0, 0,    0,            'h08,   1, 1, 'hD1,     0,            0);
        add(0, 0,        1, 0, 0,    0,            RDFO,   1, 1, 'hD1,     1,            0);
        add(0, 0,        0, 0, 0,    0,            RDFO,   1, 0, 0,        0,            0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk_i);
            v_i       = tbl[i].v[0];
            data_i    = tbl[i].d;
            ready_i   = tbl[i].rdy[0];
            wr_v_i    = tbl[i].wv[0];
            wr_addr_i = AW'(tbl[i].wa);
            wr_data_i = tbl[i].wd;
            rd_addr_i = AW'(tbl[i].ra);
            #1;
            chk("ready_o",    i, 32'(ready_o), tbl[i].er);
            chk("v_o",        i, 32'(v_o),     tbl[i].ev);
            chk("data_o",     i, data_o,       tbl[i].ed);
            chk("reg_data_o", i, reg_data_o,   tbl[i].eg);
            chk("irq_o",      i, 32'(irq_o),   tbl[i].ei);
        end

        // Asynchronous reset with two words held, checked before next edge.
        @(negedge clk_i);
        v_i = 1'b1; data_i = 32'hE1; ready_i = 1'b0; wr_v_i = 1'b0;
        rd_addr_i = AW'(RDFO);
        @(negedge clk_i);
        data_i = 32'hE2;
        @(negedge clk_i);
        v_i = 1'b0;
        #1;
        chk("pre_rst_rdfo", 0, reg_data_o,  32'd2);
        chk("pre_rst_v",    0, 32'(v_o),    32'd1);
        #1;
        reset_i = 1'b1;
        #1;
        chk("arst_v",     0, 32'(v_o),     32'd0);
        chk("arst_ready", 0, 32'(ready_o), 32'd1);
        chk("arst_data",  0, data_o,       32'd0);
        chk("arst_rdfo",  0, reg_data_o,   32'd0);
        chk("arst_irq",   0, 32'(irq_o),   32'd0);
        rd_addr_i = AW'(ISR);
        #1;
        chk("arst_isr",   0, reg_data_o,   32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;

        // Normal operation resumes after reset.
        @(negedge clk_i);
        v_i = 1'b1; data_i = 32'hF1;
        @(negedge clk_i);
        v_i = 1'b0;
        #1;
        chk("post_rst_v",    0, 32'(v_o), 32'd1);
        chk("post_rst_data", 0, data_o,   32'hF1);
        chk("post_rst_isr",  0, reg_data_o, 32'h0400_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
